micro_instr_composer: RTL and testbench
=======================================

Name: micro_instr_composer

Overview:
- Registered, parametrised microinstruction composer for the microprogrammed control unit.
- Takes the raw control-store word and the current macro instruction from the IR.
- Overlays the operand-A field, forces the bus-B select constant, and conditionally overlays the C field when the opcode matches a configurable mask.
- Sits between control-store read and the datapath decode stage; a 2-entry skid buffer gives it a valid/ready handshake so the sequencer can stall.

Parameters:
MI_W, 33, microinstruction width
IR_W, 22, macro instruction width
A_LSB, 0, LSB of A field in MI
A_W, 5, A field width (copied from IR[IR_A_LSB +: A_W])
IR_A_LSB, 0, LSB of A source in IR
B_LSB, 18, LSB of B field in MI
B_W, 6, B field width
B_CONST, 6'b100010, value forced into B field
C_LSB, 12, LSB of C field in MI
C_W, 6, C field width
IR_C_LSB, 5, LSB of C source in IR
IR_C_W, 5, C source width; must be <= C_W, zero-extended
OP_LSB, 18, LSB of opcode in IR
OP_W, 4, opcode width
C_OP_MASK, 16'h004C, bit k set => opcode k overrides C (default: opcodes 2, 3, 6)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all buffered words
in_valid  in  1  Q/instruction valid
in_ready  out  1  composer can accept
q  in  MI_W  raw control-store word
instruction  in  IR_W  current macro instruction
out_valid  out  1  out_mi valid
out_ready  in  1  downstream accepts out_mi
out_mi  out  MI_W  composed microinstruction
out_c_ovr  out  1  C field was overridden for out_mi

Behaviour:
- Reset is asynchronous and active-low, with one clock.
- Reset values: out_valid=0, out_mi=0, out_c_ovr=0, skid entry empty, in_ready=1.
- Compose function (combinational, applied at accept):
  - start from q;
  - MI[A_LSB +: A_W] = IR[IR_A_LSB +: A_W];
  - MI[B_LSB +: B_W] = B_CONST;
  - if C_OP_MASK[IR[OP_LSB +: OP_W]], MI[C_LSB +: C_W] = zero-extended IR[IR_C_LSB +: IR_C_W] and c_ovr=1; else the C field is kept from q and c_ovr=0.
- Overlay order: A, then B, then C. Later writes win if field parameters overlap.
- Accept handshake: accept = in_valid & in_ready. in_ready = ~skid_valid, driven from a register only, with no combinational path from out_ready.
- Latency: an accepted word appears on out_mi/out_valid on the next rising edge when the output stage is empty or draining.
- Output stage:
  - holds out_mi/out_c_ovr stable while out_valid & ~out_ready;
  - pops on out_valid & out_ready.
- Skid: accept while the output stage is full and not popping => word goes to the skid entry, and in_ready drops next cycle.
- Pop with skid full => skid moves to the output stage, the skid empties, and in_ready rises next cycle.
- Simultaneous pop and accept with skid empty => new word loads the output stage directly, and out_valid stays 1.
- Maximum occupancy is 2. Accepting with 2 words held is impossible because in_ready=0.
- Flush (sync) overrides accept and pop in the same cycle:
  - next cycle out_valid=0 and the skid is empty;
  - out_mi retains its value (don't-care);
  - in_ready=1.
- Reset mid-transfer: both entries are dropped immediately (async); no word is replayed.
- Ordering is strictly FIFO; throughput is 1 word/cycle while out_ready=1.

Optional Feature:
MI_PARITY_EN
- Defined: adds port out_parity (out, 1), the registered XOR-reduction of out_mi. It travels with its word through the skid, resets to 0, and is checked downstream for control-store corruption.
- Undefined: the port and its logic are absent; other behaviour is identical.

Test Plan:
- Reset, then q=33'h0, instruction=22'h1802A3 (op 6), one accept, out_ready=1 -> next cycle out_valid=1, out_mi=33'h0_0089_5003, out_c_ovr=1 (out_parity=1 if MI_PARITY_EN).
- q=33'h1_FFFF_FFFF, instruction=22'h0402A3 (op 1) -> out_mi=33'h1_FF8B_FFE3, out_c_ovr=0.
- out_ready=0, accept 3 back-to-back words W0..W2 -> W0 held on out_mi, W1 in skid, in_ready=0 from cycle 3, W2 not taken. Then out_ready=1 -> W0, W1, W2 delivered in order on consecutive cycles.
- Occupancy 2 with flush=1 and in_valid=1 on the same cycle -> next cycle out_valid=0, in_ready=1, flushed-cycle word discarded.
- rst_n pulsed low asynchronously mid-cycle with 2 words held -> out_valid=0 and in_ready=1 immediately, without waiting for clk.
- Sweep all 16 opcodes -> out_c_ovr=1 only for opcodes 2, 3, 6. Repeat with C_OP_MASK=16'h8001 -> only opcodes 0 and 15.

Source files
------------

// File: rtl/micro_instr_composer_if.sv
// Valid/ready stream bundle between the control-store read stage, the composer and datapath decode.
// MI_PARITY_EN adds the out_parity signal that travels with each composed word.
interface micro_instr_composer_if #(
  parameter int MI_W = 33,
  parameter int IR_W = 22
);
  logic            in_valid;
  logic            in_ready;
  logic [MI_W-1:0] q;
  logic [IR_W-1:0] instruction;
  logic            out_valid;
  logic            out_ready;
  logic [MI_W-1:0] out_mi;
  logic            out_c_ovr;
`ifdef MI_PARITY_EN
  logic            out_parity;

  modport master (
    output in_valid, q, instruction, out_ready,
    input  in_ready, out_valid, out_mi, out_c_ovr, out_parity
  );
  modport slave (
    input  in_valid, q, instruction, out_ready,
    output in_ready, out_valid, out_mi, out_c_ovr, out_parity
  );
`else
  modport master (
    output in_valid, q, instruction, out_ready,
    input  in_ready, out_valid, out_mi, out_c_ovr
  );
  modport slave (
    input  in_valid, q, instruction, out_ready,
    output in_ready, out_valid, out_mi, out_c_ovr
  );
`endif
endinterface

// File: rtl/micro_instr_composer.sv
// Overlays A/B/C fields from the IR onto the control-store word, behind a 2-entry skid buffer.
// Optional MI_PARITY_EN: registered XOR parity of each composed word on out_parity.
module micro_instr_composer #(
  parameter int                   MI_W      = 33,
  parameter int                   IR_W      = 22,
  parameter int                   A_LSB     = 0,
  parameter int                   A_W       = 5,
  parameter int                   IR_A_LSB  = 0,
  parameter int                   B_LSB     = 18,
  parameter int                   B_W       = 6,
  parameter logic [B_W-1:0]       B_CONST   = 6'b100010,
  parameter int                   C_LSB     = 12,
  parameter int                   C_W       = 6,
  parameter int                   IR_C_LSB  = 5,
  parameter int                   IR_C_W    = 5,
  parameter int                   OP_LSB    = 18,
  parameter int                   OP_W      = 4,
  parameter logic [(1<<OP_W)-1:0] C_OP_MASK = 16'h004C
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  flush,
  micro_instr_composer_if.slave bus
);

  logic [MI_W-1:0] comp_mi;
  logic            comp_c;
  logic [OP_W-1:0] op;

  logic            out_valid_r;
  logic [MI_W-1:0] out_mi_r;
  logic            out_c_r;
  logic            skid_valid;
  logic [MI_W-1:0] skid_mi;
  logic            skid_c;
  logic            accept;

  // Overlay order A, B, C: later fields win when parameters make them overlap.
  always_comb begin
    comp_mi = bus.q;
    comp_mi[A_LSB +: A_W] = bus.instruction[IR_A_LSB +: A_W];
    comp_mi[B_LSB +: B_W] = B_CONST;
    op     = bus.instruction[OP_LSB +: OP_W];
    comp_c = C_OP_MASK[op];
    if (comp_c)
      comp_mi[C_LSB +: C_W] = C_W'(bus.instruction[IR_C_LSB +: IR_C_W]);
  end

  assign accept = bus.in_valid & ~skid_valid;

`ifdef MI_PARITY_EN
  logic out_par_r;
  logic skid_par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_mi_r    <= '0;
      out_c_r     <= 1'b0;
      skid_valid  <= 1'b0;
      skid_mi     <= '0;
      skid_c      <= 1'b0;
`ifdef MI_PARITY_EN
      out_par_r   <= 1'b0;
      skid_par    <= 1'b0;
`endif
    end else if (flush) begin
      out_valid_r <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (!out_valid_r || bus.out_ready) begin
      // Output stage is free or draining: refill from skid first to keep FIFO order.
      if (skid_valid) begin
        out_valid_r <= 1'b1;
        out_mi_r    <= skid_mi;
        out_c_r     <= skid_c;
        skid_valid  <= 1'b0;
`ifdef MI_PARITY_EN
        out_par_r   <= skid_par;
`endif
      end else begin
        out_valid_r <= accept;
        if (accept) begin
          out_mi_r  <= comp_mi;
          out_c_r   <= comp_c;
`ifdef MI_PARITY_EN
          out_par_r <= ^comp_mi;
`endif
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_mi    <= comp_mi;
      skid_c     <= comp_c;
`ifdef MI_PARITY_EN
      skid_par   <= ^comp_mi;
`endif
    end
  end

  assign bus.in_ready  = ~skid_valid;
  assign bus.out_valid = out_valid_r;
  assign bus.out_mi    = out_mi_r;
  assign bus.out_c_ovr = out_c_r;
`ifdef MI_PARITY_EN
  assign bus.out_parity = out_par_r;
`endif

endmodule

// File: tb/tb_micro_instr_composer.sv
// Self-checking bench for micro_instr_composer: directed vectors, skid/flush/reset corners,
// opcode sweep against two C_OP_MASK settings, and a randomized stream against a queue model.
module tb_micro_instr_composer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  micro_instr_composer_if #(.MI_W(33), .IR_W(22)) bus ();
  micro_instr_composer_if #(.MI_W(33), .IR_W(22)) bus_m ();

  micro_instr_composer dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave));
  micro_instr_composer #(.C_OP_MASK(16'h8001)) dut_m (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_m.slave));

  assign bus_m.in_valid    = bus.in_valid;
  assign bus_m.q           = bus.q;
  assign bus_m.instruction = bus.instruction;
  assign bus_m.out_ready   = bus.out_ready;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] mdl[$];
  logic [33:0] mdl_m[$];

  // Reference compose using plain mask arithmetic; result is {c_ovr, mi}.
  function automatic logic [33:0] ref_model(input logic [32:0] qv, input logic [21:0] ir,
                                            input logic [15:0] mask);
    longint unsigned mi, a, c, op;
    bit ovr;
    mi = 64'(qv);
    a  = 64'(ir) & 64'h1F;
    mi = (mi & ~64'h1F) | a;
    mi = (mi & ~(64'h3F << 18)) | (64'h22 << 18);
    op = (64'(ir) >> 18) & 64'hF;
    ovr = ((64'(mask) >> op) & 64'h1) != 0;
    if (ovr) begin
      c  = (64'(ir) >> 5) & 64'h1F;
      mi = (mi & ~(64'h3F << 12)) | (c << 12);
    end
    return {ovr, 33'(mi)};
  endfunction

  // Applies one cycle of stimulus and advances the model; comparisons are done by callers.
  task automatic drive(input bit iv, input logic [32:0] qv, input logic [21:0] ir,
                       input bit ordy, input bit fl);
    bit acc, pop;
    bus.in_valid    = iv;
    bus.q           = qv;
    bus.instruction = ir;
    bus.out_ready   = ordy;
    flush           = fl;
    if (fl) begin
      mdl.delete();
      mdl_m.delete();
    end else begin
      acc = iv && (mdl.size() < 2);
      pop = ordy && (mdl.size() > 0);
      if (pop) begin
        void'(mdl.pop_front());
        void'(mdl_m.pop_front());
      end
      if (acc) begin
        mdl.push_back(ref_model(qv, ir, 16'h004C));
        mdl_m.push_back(ref_model(qv, ir, 16'h8001));
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [32:0] rnd_q();
    return {1'($urandom), 32'($urandom)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.q = '0; bus.instruction = '0; bus.out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_mi !== 33'h0) begin n_fail++; $display("FAIL reset_out_mi got %h want 0", bus.out_mi); end
    n_checks++; if (bus.out_c_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_out_c_ovr got %b want 0", bus.out_c_ovr); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
`ifdef MI_PARITY_EN
    n_checks++; if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL reset_out_parity got %b want 0", bus.out_parity); end
`endif
    rst_n = 1'b1;
    mdl.delete(); mdl_m.delete();
    @(negedge clk);
  endtask

  task automatic test_directed();
    drive(1'b1, 33'h0, 22'h1802A3, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dir1_out_valid got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_mi !== 33'h0_0089_5003) begin n_fail++; $display("FAIL dir1_out_mi got %h want 000895003", bus.out_mi); end
    n_checks++; if (bus.out_c_ovr !== 1'b1) begin n_fail++; $display("FAIL dir1_c_ovr got %b want 1", bus.out_c_ovr); end
`ifdef MI_PARITY_EN
    n_checks++; if (bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL dir1_parity got %b want 1", bus.out_parity); end
`endif
    drive(1'b1, 33'h1_FFFF_FFFF, 22'h0402A3, 1'b1, 1'b0);
    n_checks++; if (bus.out_mi !== 33'h1_FF8B_FFE3) begin n_fail++; $display("FAIL dir2_out_mi got %h want 1ff8bffe3", bus.out_mi); end
    n_checks++; if (bus.out_c_ovr !== 1'b0) begin n_fail++; $display("FAIL dir2_c_ovr got %b want 0", bus.out_c_ovr); end
    drive(1'b0, 33'h0, 22'h0, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_drain_out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] w[3];
    logic [21:0] ir[3];
    logic [33:0] e[3];
    for (int i = 0; i < 3; i++) begin
      w[i] = rnd_q(); ir[i] = 22'($urandom);
      e[i] = ref_model(w[i], ir[i], 16'h004C);
    end
    drive(1'b1, w[0], ir[0], 1'b0, 1'b0);
    n_checks++; if (bus.out_mi !== e[0][32:0]) begin n_fail++; $display("FAIL b2b_c1_mi got %h want %h", bus.out_mi, e[0][32:0]); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_c1_in_ready got %b want 1", bus.in_ready); end
    drive(1'b1, w[1], ir[1], 1'b0, 1'b0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_c2_in_ready got %b want 0", bus.in_ready); end
    drive(1'b1, w[2], ir[2], 1'b0, 1'b0);
    n_checks++; if (bus.out_mi !== e[0][32:0]) begin n_fail++; $display("FAIL b2b_hold_mi got %h want %h", bus.out_mi, e[0][32:0]); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_c3_in_ready got %b want 0", bus.in_ready); end
    drive(1'b1, w[2], ir[2], 1'b1, 1'b0);
    n_checks++; if (bus.out_mi !== e[1][32:0]) begin n_fail++; $display("FAIL b2b_w1_mi got %h want %h", bus.out_mi, e[1][32:0]); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_w1_in_ready got %b want 1", bus.in_ready); end
    drive(1'b1, w[2], ir[2], 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_mi !== e[2][32:0]) begin n_fail++; $display("FAIL b2b_w2_mi got %b/%h want 1/%h", bus.out_valid, bus.out_mi, e[2][32:0]); end
    n_checks++; if (bus.out_c_ovr !== e[2][33]) begin n_fail++; $display("FAIL b2b_w2_c_ovr got %b want %b", bus.out_c_ovr, e[2][33]); end
    drive(1'b0, 33'h0, 22'h0, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, rnd_q(), 22'($urandom), 1'b0, 1'b0);
    drive(1'b1, rnd_q(), 22'($urandom), 1'b0, 1'b0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full_in_ready got %b want 0", bus.in_ready); end
    drive(1'b1, rnd_q(), 22'($urandom), 1'b0, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
    drive(1'b0, 33'h0, 22'h0, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard got %b want 0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, rnd_q(), 22'($urandom), 1'b0, 1'b0);
    drive(1'b1, rnd_q(), 22'($urandom), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready got %b want 1", bus.in_ready); end
    #1 rst_n = 1'b1;
    mdl.delete(); mdl_m.delete();
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_no_replay got %b want 0", bus.out_valid); end
  endtask

  task automatic test_opcode_sweep();
    logic [21:0] ir;
    for (int op = 0; op < 16; op++) begin
      ir = {4'(op), 18'($urandom)};
      drive(1'b1, rnd_q(), ir, 1'b1, 1'b0);
      n_checks++; if (bus.out_c_ovr !== 1'((16'h004C >> op) & 16'h1)) begin n_fail++; $display("FAIL sweep_c_ovr op=%0d got %b want %b", op, bus.out_c_ovr, 1'((16'h004C >> op) & 16'h1)); end
      n_checks++; if (bus_m.out_c_ovr !== 1'((16'h8001 >> op) & 16'h1)) begin n_fail++; $display("FAIL sweep_m_c_ovr op=%0d got %b want %b", op, bus_m.out_c_ovr, 1'((16'h8001 >> op) & 16'h1)); end
      n_checks++; if (bus.out_mi !== mdl[0][32:0]) begin n_fail++; $display("FAIL sweep_mi op=%0d got %h want %h", op, bus.out_mi, mdl[0][32:0]); end
      n_checks++; if (bus_m.out_mi !== mdl_m[0][32:0]) begin n_fail++; $display("FAIL sweep_m_mi op=%0d got %h want %h", op, bus_m.out_mi, mdl_m[0][32:0]); end
    end
    drive(1'b0, 33'h0, 22'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd_q(), 22'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      n_checks++; if (bus.out_valid !== (mdl.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid i=%0d got %b want %b", i, bus.out_valid, mdl.size() > 0); end
      n_checks++; if (bus.in_ready !== (mdl.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready i=%0d got %b want %b", i, bus.in_ready, mdl.size() < 2); end
      if (mdl.size() > 0) begin
        n_checks++; if (bus.out_mi !== mdl[0][32:0]) begin n_fail++; $display("FAIL rnd_out_mi i=%0d got %h want %h", i, bus.out_mi, mdl[0][32:0]); end
        n_checks++; if (bus.out_c_ovr !== mdl[0][33]) begin n_fail++; $display("FAIL rnd_c_ovr i=%0d got %b want %b", i, bus.out_c_ovr, mdl[0][33]); end
`ifdef MI_PARITY_EN
        n_checks++; if (bus.out_parity !== ^mdl[0][32:0]) begin n_fail++; $display("FAIL rnd_parity i=%0d got %b want %b", i, bus.out_parity, ^mdl[0][32:0]); end
`endif
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_opcode_sweep();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
